// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared definitions for the draw-command dispatcher.
//   - opcode constants for the shape units and the idle/no-op code
//   - dispatcher state encoding
//   - op_to_done_idx: maps an opcode to its bit in the UNIT_DONE vector
//   - op_is_shape:    true for opcodes that start a shape unit
package gpu_cmd_pkg;

  localparam logic [3:0] OP_CF   = 4'd0;
  localparam logic [3:0] OP_CD   = 4'd1;
  localparam logic [3:0] OP_RF   = 4'd2;
  localparam logic [3:0] OP_RD   = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_FU   = 4'd10;
  localparam logic [3:0] OP_IDLE = 4'd15;

  localparam logic [2:0] DONE_IDX_FU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Opcodes 0-4 map straight onto done bits 0-4; frame update uses bit 5.
  function automatic logic [2:0] op_to_done_idx(input logic [3:0] op);
    return (op == OP_FU) ? DONE_IDX_FU : op[2:0];
  endfunction

  function automatic logic op_is_shape(input logic [3:0] op);
    return (op <= OP_LD) || (op == OP_FU);
  endfunction

endpackage

// File: rtl/gpu_cmd_dispatch_watchdog.sv
// gpu_watchdog: saturating up-counter bounding how long the dispatcher waits
// for a shape unit.
//   CLK   in  system clock
//   RST_N in  synchronous active-low reset
//   clr   in  force the count to zero
//   en    in  count this cycle
//   tc    out the count reaches TIMEOUT-1 at the coming edge
module gpu_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT - 1);
  localparam logic [W-1:0] CNT_PRE = W'(TIMEOUT - 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Flag the cycle whose increment lands on TIMEOUT-1, so the abort is taken
  // on the same edge the counter reaches its limit.
  assign tc = en && !clr && (cnt_q == CNT_PRE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpu_cmd_dispatch.sv
// gpu_cmd_dispatch: accepts draw commands, steers the unit-select bus, starts
// the selected shape unit and waits for its done with a watchdog.
//   CLK, RST_N                    clock, synchronous active-low reset
//   CMD_VALID/CMD_READY           command handshake (READY high only in IDLE)
//   CMD_OP, CMD_COLOR, CMD_X0..Y1 command fields
//   SEL, START                    unit select and one-cycle start strobe
//   P_COLOR, P_X0..P_Y1           parameters latched at command accept
//   UNIT_DONE                     per-unit done (bits 0-4 = ops 0-4, bit 5 = FU)
//   CMD_DONE, BUSY                completion pulse, not-idle indicator
//   ERR_OP, ERR_TO, ERR_CLR       sticky illegal-op / timeout flags and clear
//
// state | meaning
// IDLE  | ready for a command, SEL parked at 15
// ISSUE | START pulsed to selected unit, watchdog cleared
// WAIT  | SEL held, watchdog running, waiting for the unit's done
// DONE  | SEL held for the final colour capture, CMD_DONE pulsed
module gpu_cmd_dispatch
  import gpu_cmd_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [3:0]         CMD_OP,
  input  logic [15:0]        CMD_COLOR,
  input  logic [COORD_W-1:0] CMD_X0,
  input  logic [COORD_W-1:0] CMD_Y0,
  input  logic [COORD_W-1:0] CMD_X1,
  input  logic [COORD_W-1:0] CMD_Y1,
  output logic [3:0]         SEL,
  output logic               START,
  output logic [15:0]        P_COLOR,
  output logic [COORD_W-1:0] P_X0,
  output logic [COORD_W-1:0] P_Y0,
  output logic [COORD_W-1:0] P_X1,
  output logic [COORD_W-1:0] P_Y1,
  input  logic [5:0]         UNIT_DONE,
  output logic               CMD_DONE,
  output logic               BUSY,
  output logic               ERR_OP,
  output logic               ERR_TO,
  input  logic               ERR_CLR
);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [15:0]        p_color_q, p_color_d;
  logic [COORD_W-1:0] p_x0_q, p_x0_d;
  logic [COORD_W-1:0] p_y0_q, p_y0_d;
  logic [COORD_W-1:0] p_x1_q, p_x1_d;
  logic [COORD_W-1:0] p_y1_q, p_y1_d;
  logic               err_op_q, err_op_d;
  logic               err_to_q, err_to_d;
  logic               wd_clr, wd_en, wd_tc;
  logic               unit_done_sel;

  gpu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  assign unit_done_sel = UNIT_DONE[op_to_done_idx(op_q)];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    p_color_d = p_color_q;
    p_x0_d    = p_x0_q;
    p_y0_d    = p_y0_q;
    p_x1_d    = p_x1_q;
    p_y1_d    = p_y1_q;
    err_op_d  = err_op_q;
    err_to_d  = err_to_q;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    // Clear first so a set event later in this block takes priority.
    if (ERR_CLR) begin
      err_op_d = 1'b0;
      err_to_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (op_is_shape(CMD_OP)) begin
            op_d      = CMD_OP;
            p_color_d = CMD_COLOR;
            p_x0_d    = CMD_X0;
            p_y0_d    = CMD_Y0;
            p_x1_d    = CMD_X1;
            p_y1_d    = CMD_Y1;
            state_d   = ST_ISSUE;
          end else if (CMD_OP != OP_IDLE) begin
            err_op_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (unit_done_sel) begin
          state_d = ST_DONE;
        end else if (wd_tc) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    CMD_READY = (state_q == ST_IDLE);
    BUSY      = (state_q != ST_IDLE);
    START     = (state_q == ST_ISSUE);
    CMD_DONE  = (state_q == ST_DONE);
    SEL       = (state_q == ST_IDLE) ? OP_IDLE : op_q;
  end

  assign P_COLOR = p_color_q;
  assign P_X0    = p_x0_q;
  assign P_Y0    = p_y0_q;
  assign P_X1    = p_x1_q;
  assign P_Y1    = p_y1_q;
  assign ERR_OP  = err_op_q;
  assign ERR_TO  = err_to_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_IDLE;
      p_color_q <= '0;
      p_x0_q    <= '0;
      p_y0_q    <= '0;
      p_x1_q    <= '0;
      p_y1_q    <= '0;
      err_op_q  <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      p_color_q <= p_color_d;
      p_x0_q    <= p_x0_d;
      p_y0_q    <= p_y0_d;
      p_x1_q    <= p_x1_d;
      p_y1_q    <= p_y1_d;
      err_op_q  <= err_op_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// Directed bench for gpu_cmd_dispatch with TIMEOUT = 8. Inputs change and
// outputs are checked on the falling clock edge.
module tb_gpu_cmd_dispatch;

  localparam int COORD_W = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [15:0]        cmd_color;
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0]         sel;
  logic               start;
  logic [15:0]        p_color;
  logic [COORD_W-1:0] p_x0, p_y0, p_x1, p_y1;
  logic [5:0]         unit_done;
  logic               cmd_done;
  logic               busy;
  logic               err_op;
  logic               err_to;
  logic               err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  gpu_cmd_dispatch #(
    .COORD_W(COORD_W),
    .TIMEOUT(8)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_OP   (cmd_op),
    .CMD_COLOR(cmd_color),
    .CMD_X0   (cmd_x0),
    .CMD_Y0   (cmd_y0),
    .CMD_X1   (cmd_x1),
    .CMD_Y1   (cmd_y1),
    .SEL      (sel),
    .START    (start),
    .P_COLOR  (p_color),
    .P_X0     (p_x0),
    .P_Y0     (p_y0),
    .P_X1     (p_x1),
    .P_Y1     (p_y1),
    .UNIT_DONE(unit_done),
    .CMD_DONE (cmd_done),
    .BUSY     (busy),
    .ERR_OP   (err_op),
    .ERR_TO   (err_to),
    .ERR_CLR  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] col,
                      input int x0, input int y0, input int x1, input int y1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_color = col;
    cmd_x0    = COORD_W'(x0);
    cmd_y0    = COORD_W'(y0);
    cmd_x1    = COORD_W'(x1);
    cmd_y1    = COORD_W'(y1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd15;
    cmd_color = '0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    unit_done = '0;
    err_clr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 15);
    chk("rst_start", start, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_op", err_op, 0);
    chk("rst_err_to", err_to, 0);
    chk("rst_p_color", p_color, 0);
    chk("rst_p_x1", p_x1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    // RF, done in the 5th WAIT cycle
    send(4'd2, 16'hF800, 10, 20, 30, 40);
    chk("rf_ready_acc", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x0 = 10'd999; cmd_y0 = 10'd999; cmd_x1 = 10'd999; cmd_y1 = 10'd999;
    cmd_color = 16'h0000;
    chk("rf_issue_start", start, 1);
    chk("rf_issue_sel", sel, 2);
    chk("rf_issue_busy", busy, 1);
    chk("rf_p_color", p_color, 16'hF800);
    chk("rf_p_x0", p_x0, 10);
    chk("rf_p_y0", p_y0, 20);
    chk("rf_p_x1", p_x1, 30);
    chk("rf_p_y1", p_y1, 40);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("rf_wait_start", start, 0);
      chk("rf_wait_sel", sel, 2);
      chk("rf_wait_done", cmd_done, 0);
      chk("rf_wait_ready", cmd_ready, 0);
      chk("rf_wait_p_x0", p_x0, 10);
      if (i == 5) unit_done = 6'b000100;
    end
    @(negedge clk);
    unit_done = '0;
    chk("rf_done_pulse", cmd_done, 1);
    chk("rf_done_sel", sel, 2);
    chk("rf_done_p_y1", p_y1, 40);
    chk("rf_done_start", start, 0);
    @(negedge clk);
    chk("rf_post_done", cmd_done, 0);
    chk("rf_post_ready", cmd_ready, 1);
    chk("rf_post_sel", sel, 15);
    chk("rf_post_busy", busy, 0);
    chk("rf_post_p_color", p_color, 16'hF800);

    // Illegal opcode 7, then clear
    send(4'd7, 16'h1111, 1, 1, 1, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("op7_err", err_op, 1);
    chk("op7_start", start, 0);
    chk("op7_sel", sel, 15);
    chk("op7_ready", cmd_ready, 1);
    chk("op7_busy", busy, 0);
    chk("op7_p_x0", p_x0, 10);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("op7_clr", err_op, 0);

    // Illegal op together with ERR_CLR: set wins
    send(4'd12, 16'h2222, 2, 2, 2, 2);
    err_clr = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    err_clr = 1'b0;
    chk("op12_set_wins", err_op, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("op12_clr", err_op, 0);

    // Op 15 no-op
    send(4'd15, 16'h1234, 1, 2, 3, 4);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("nop_start", start, 0);
    chk("nop_busy", busy, 0);
    chk("nop_done", cmd_done, 0);
    chk("nop_err", err_op, 0);
    chk("nop_p_color", p_color, 16'hF800);
    chk("nop_ready", cmd_ready, 1);
    @(negedge clk);
    chk("nop_done2", cmd_done, 0);
    chk("nop_busy2", busy, 0);

    // LD with no done: timeout after 7 WAIT cycles
    send(4'd4, 16'h07E0, 5, 6, 7, 8);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ld_start", start, 1);
    chk("ld_sel", sel, 4);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("ld_wait_busy", busy, 1);
      chk("ld_wait_err_to", err_to, 0);
      chk("ld_wait_done", cmd_done, 0);
      chk("ld_wait_sel", sel, 4);
    end
    @(negedge clk);
    chk("ld_to_err", err_to, 1);
    chk("ld_to_sel", sel, 15);
    chk("ld_to_busy", busy, 0);
    chk("ld_to_done", cmd_done, 0);
    chk("ld_to_ready", cmd_ready, 1);
    @(negedge clk);
    chk("ld_to_done2", cmd_done, 0);
    chk("ld_to_sticky", err_to, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ld_to_clr", err_to, 0);

    // CD: done during ISSUE and wrong-unit done are ignored
    send(4'd1, 16'h0F0F, 50, 60, 25, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    unit_done = 6'b000010;
    chk("cd_start", start, 1);
    chk("cd_sel", sel, 1);
    @(negedge clk);
    unit_done = 6'b001000;
    chk("cd_w1_done", cmd_done, 0);
    chk("cd_w1_busy", busy, 1);
    chk("cd_w1_sel", sel, 1);
    @(negedge clk);
    unit_done = '0;
    chk("cd_w2_done", cmd_done, 0);
    chk("cd_w2_busy", busy, 1);
    @(negedge clk);
    unit_done = 6'b000010;
    chk("cd_w3_done", cmd_done, 0);
    chk("cd_w3_sel", sel, 1);
    @(negedge clk);
    unit_done = '0;
    chk("cd_done_pulse", cmd_done, 1);
    chk("cd_done_sel", sel, 1);
    @(negedge clk);
    chk("cd_post_done", cmd_done, 0);
    chk("cd_post_ready", cmd_ready, 1);

    // CD with done exactly at terminal count: done wins
    send(4'd1, 16'h0F0F, 50, 60, 25, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("cdtc_wait_done", cmd_done, 0);
      chk("cdtc_wait_busy", busy, 1);
      if (i == 7) unit_done = 6'b000010;
    end
    @(negedge clk);
    unit_done = '0;
    chk("cdtc_done_pulse", cmd_done, 1);
    chk("cdtc_err_to", err_to, 0);
    chk("cdtc_sel", sel, 1);
    @(negedge clk);
    chk("cdtc_post_ready", cmd_ready, 1);
    chk("cdtc_post_err_to", err_to, 0);

    // Reset during FU WAIT, with ERR_OP set beforehand
    send(4'd9, 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fu_pre_err_op", err_op, 1);
    send(4'd10, 16'hABCD, 100, 200, 300, 400);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fu_start", start, 1);
    chk("fu_sel", sel, 10);
    @(negedge clk);
    @(negedge clk);
    chk("fu_wait_busy", busy, 1);
    chk("fu_wait_sel", sel, 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("fu_rst_sel", sel, 15);
    chk("fu_rst_busy", busy, 0);
    chk("fu_rst_start", start, 0);
    chk("fu_rst_done", cmd_done, 0);
    chk("fu_rst_err_op", err_op, 0);
    chk("fu_rst_err_to", err_to, 0);
    chk("fu_rst_p_color", p_color, 0);
    chk("fu_rst_p_x1", p_x1, 0);
    chk("fu_rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // RD after reset completes normally
    send(4'd3, 16'h001F, 11, 22, 33, 44);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_start", start, 1);
    chk("rd_sel", sel, 3);
    chk("rd_p_x0", p_x0, 11);
    chk("rd_p_y1", p_y1, 44);
    @(negedge clk);
    unit_done = 6'b001000;
    chk("rd_w1_done", cmd_done, 0);
    @(negedge clk);
    unit_done = '0;
    chk("rd_done_pulse", cmd_done, 1);
    chk("rd_done_sel", sel, 3);
    chk("rd_done_ready", cmd_ready, 0);
    // Hold a FU command from the DONE cycle: accepted in the first IDLE cycle
    send(4'd10, 16'hFFFF, 1, 1, 1, 1);
    @(negedge clk);
    chk("b2b_idle_ready", cmd_ready, 1);
    chk("b2b_idle_sel", sel, 15);
    chk("b2b_idle_done", cmd_done, 0);
    chk("b2b_idle_start", start, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_fu_start", start, 1);
    chk("b2b_fu_sel", sel, 10);
    chk("b2b_fu_p_color", p_color, 16'hFFFF);
    @(negedge clk);
    unit_done = 6'b100000;
    chk("b2b_fu_wait_sel", sel, 10);
    chk("b2b_fu_wait_done", cmd_done, 0);
    @(negedge clk);
    unit_done = '0;
    chk("b2b_fu_done", cmd_done, 1);
    @(negedge clk);
    chk("b2b_fu_post_done", cmd_done, 0);
    chk("b2b_fu_post_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
